// File: rtl/dffs_reg_pkg.sv
// Shared definitions for the multi-mode register: MODE encoding and its enumeration.
package dffs_reg_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_UP   = 3'b100,
        MODE_DOWN = 3'b101,
        MODE_ROL  = 3'b110,
        MODE_ROR  = 3'b111
    } mode_e;

endpackage

// File: rtl/dffs_reg_next.sv
// Combinational next-state selection for the register, one result per MODE value.
module dffs_reg_next
    import dffs_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  q,
    input  logic [WIDTH-1:0]  d,
    input  logic              si,
    input  logic [MODE_W-1:0] mode,
    output logic [WIDTH-1:0]  q_next
);

    always_comb begin
        q_next = q;
        case (mode_e'(mode))
            MODE_HOLD: q_next = q;
            MODE_LOAD: q_next = d;
            MODE_SHL:  q_next = {q[WIDTH-2:0], si};
            MODE_SHR:  q_next = {si, q[WIDTH-1:1]};
            // Counting relies on natural wrap of the WIDTH-bit sum.
            MODE_UP:   q_next = q + WIDTH'(1);
            MODE_DOWN: q_next = q - WIDTH'(1);
            MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            default:   q_next = q;
        endcase
    end

endmodule

// File: rtl/dffs_reg_n.sv
// Multi-mode WIDTH-bit register: reset / set / enable priority around a single state
// register, with combinational complement, serial-out and terminal-count outputs.
module dffs_reg_n
    import dffs_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              SN,
    input  logic              EN,
    input  logic [MODE_W-1:0] MODE,
    input  logic [WIDTH-1:0]  D,
    input  logic              SI,
    output logic [WIDTH-1:0]  Q,
    output logic [WIDTH-1:0]  QN,
    output logic              SO,
    output logic              TC
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;

    dffs_reg_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .q      (q_reg),
        .d      (D),
        .si     (SI),
        .mode   (MODE),
        .q_next (q_next)
    );

    // Exactly one action per edge: reset beats set beats hold beats the selected mode.
    always_ff @(posedge CK) begin
        if (RST) begin
            q_reg <= RESET_VAL;
        end else if (!SN) begin
            q_reg <= '1;
        end else if (EN) begin
            q_reg <= q_next;
        end
    end

    assign Q = q_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_qn
            assign QN[gi] = ~q_reg[gi];
        end
    endgenerate

    // SO tracks the bit about to leave the register and ignores EN.
    always_comb begin
        SO = 1'b0;
        case (mode_e'(MODE))
            MODE_SHL, MODE_ROL: SO = q_reg[WIDTH-1];
            MODE_SHR, MODE_ROR: SO = q_reg[0];
            default:            SO = 1'b0;
        endcase
    end

    always_comb begin
        TC = 1'b0;
        if (EN && SN && !RST) begin
            if (mode_e'(MODE) == MODE_UP && (&q_reg)) begin
                TC = 1'b1;
            end else if (mode_e'(MODE) == MODE_DOWN && q_reg == '0) begin
                TC = 1'b1;
            end
        end
    end

endmodule
